// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction fetch stage
//
// Purpose: owns the PC, issues one instruction-memory request at a time,
// holds the returned instruction in a one-entry register for decode, and
// applies branch/jump redirects and halt.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr       memory request and address (address == pc)
//   imem_ack/imem_rdata      memory accept with same-cycle read data
//   instr/instr_valid        held instruction and its valid flag to decode
//   instr_ready              decode consumes instr this cycle
//   pc/pc_plus_1             address of held or in-flight instruction, and pc+1
//   take_branch/next_pc      redirect request and target
//   halt/halted              stop-fetch request, unit-is-halted indication

module fetch_unit #(
   parameter int unsigned PC_WIDTH    = 10,
   parameter int unsigned INSTR_WIDTH = 8,
   parameter int unsigned RESET_PC    = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [PC_WIDTH-1:0]    pc_plus_1,
   input  logic                   take_branch,
   input  logic [PC_WIDTH-1:0]    next_pc,
   input  logic                   halt,
   output logic                   halted
);

   localparam logic [PC_WIDTH-1:0] RESET_PC_L = PC_WIDTH'(RESET_PC);

   typedef enum logic [1:0] {
      S_START,
      S_FETCH,
      S_HOLD,
      S_HALTED
   } state_e;

   state_e                 state_q,     state_d;
   logic [PC_WIDTH-1:0]    pc_q,        pc_d;
   logic [INSTR_WIDTH-1:0] instr_q,     instr_d;
   logic                   redir_pend_q, redir_pend_d;
   logic [PC_WIDTH-1:0]    redir_tgt_q, redir_tgt_d;
   logic                   halt_pend_q, halt_pend_d;
   logic                   imem_req_q;
   logic                   instr_valid_q;
   logic                   halted_q;
   logic                   halt_now;

   assign pc_plus_1 = pc_q + PC_WIDTH'(1);

   // A halt seen this cycle counts as already pending so that a halt arriving
   // together with the completing event takes effect immediately.
   assign halt_now = halt_pend_q | halt;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      halt_pend_d  = halt_pend_q;

      case (state_q)
         S_START: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            halt_pend_d = halt_now;
            if (imem_ack) begin
               // A redirect seen at any point during the request wins over
               // the returned data; the current-cycle target beats a stored one.
               if (take_branch) begin
                  pc_d = next_pc;
               end else if (redir_pend_q) begin
                  pc_d = redir_tgt_q;
               end
               redir_pend_d = 1'b0;
               if (halt_now) begin
                  state_d = S_HALTED;
               end else if (!(take_branch || redir_pend_q)) begin
                  instr_d = imem_rdata;
                  state_d = S_HOLD;
               end
            end else if (take_branch) begin
               // The request cannot be abandoned, so remember the target
               // until the ack arrives; a later redirect overwrites it.
               redir_tgt_d  = next_pc;
               redir_pend_d = 1'b1;
            end
         end

         S_HOLD: begin
            halt_pend_d = halt_now;
            // Redirect takes priority over a normal consume.
            if (take_branch || instr_ready) begin
               pc_d    = take_branch ? next_pc : pc_plus_1;
               state_d = halt_now ? S_HALTED : S_FETCH;
            end
         end

         S_HALTED: begin
         end

         default: begin
            state_d = S_START;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_START;
         pc_q          <= RESET_PC_L;
         instr_q       <= '0;
         redir_pend_q  <= 1'b0;
         redir_tgt_q   <= '0;
         halt_pend_q   <= 1'b0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         redir_pend_q  <= redir_pend_d;
         redir_tgt_q   <= redir_tgt_d;
         halt_pend_q   <= halt_pend_d;
         imem_req_q    <= (state_d == S_FETCH);
         instr_valid_q <= (state_d == S_HOLD);
         halted_q      <= (state_d == S_HALTED);
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit

module tb_fetch_unit;

   localparam int PW = 10;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_rdata = '0;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [PW-1:0] pc;
   logic [PW-1:0] pc_plus_1;
   logic          take_branch = 1'b0;
   logic [PW-1:0] next_pc = '0;
   logic          halt = 1'b0;
   logic          halted;

   fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .pc_plus_1   (pc_plus_1),
      .take_branch (take_branch),
      .next_pc     (next_pc),
      .halt        (halt),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what the fetch stage is architecturally doing.
   typedef enum logic [1:0] {P_BOOT, P_AWAIT, P_PRESENT, P_STOP} phase_e;
   phase_e        m_mode;
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_tgt;
   logic [IW-1:0] m_instr;
   bit            m_pend;
   bit            m_halt;

   logic [PW-1:0]    req_q[$];
   logic [PW+IW-1:0] dec_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = P_BOOT;
      m_pc    = '0;
      m_tgt   = '0;
      m_instr = '0;
      m_pend  = 0;
      m_halt  = 0;
   endtask

   // Drive one cycle of inputs, advance the model across the coming edge,
   // then return 1 time unit after that edge.
   task automatic step(input bit ack, input logic [IW-1:0] rd, input bit rdy,
                       input bit tb, input logic [PW-1:0] npc, input bit hlt);
      bit drop;
      imem_ack    = ack;
      imem_rdata  = rd;
      instr_ready = rdy;
      take_branch = tb;
      next_pc     = npc;
      halt        = hlt;
      case (m_mode)
         P_BOOT: m_mode = P_AWAIT;
         P_AWAIT: begin
            if (hlt) m_halt = 1;
            if (ack) begin
               req_q.push_back(m_pc);
               drop = tb || m_pend;
               if (tb) m_pc = npc;
               else if (m_pend) m_pc = m_tgt;
               m_pend = 0;
               if (m_halt) m_mode = P_STOP;
               else if (!drop) begin
                  m_instr = rd;
                  m_mode  = P_PRESENT;
               end
            end else if (tb) begin
               m_tgt  = npc;
               m_pend = 1;
            end
         end
         P_PRESENT: begin
            if (hlt) m_halt = 1;
            if (tb || rdy) begin
               dec_q.push_back({m_pc, m_instr});
               m_pc   = tb ? npc : PW'(m_pc + 1);
               m_mode = m_halt ? P_STOP : P_AWAIT;
            end
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic rstep(input bit hlt);
      step(1'($urandom_range(0, 1)), IW'($urandom), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) == 0), PW'($urandom), hlt);
   endtask

   task automatic check_model();
      logic [PW-1:0] exp_p1;
      exp_p1 = PW'(m_pc + 1);
      chk("m_imem_req",    32'(imem_req),    32'(m_mode == P_AWAIT));
      chk("m_instr_valid", 32'(instr_valid), 32'(m_mode == P_PRESENT));
      chk("m_halted",      32'(halted),      32'(m_mode == P_STOP));
      chk("m_pc",          32'(pc),          32'(m_pc));
      chk("m_imem_addr",   32'(imem_addr),   32'(m_pc));
      chk("m_pc_plus_1",   32'(pc_plus_1),   32'(exp_p1));
   endtask

   // Assert reset (asynchronously, mid-cycle), check reset state, release.
   task automatic do_reset();
      rst_n    = 1'b0;
      imem_ack = 1'b1;
      #1;
      chk("rst_imem_req",    32'(imem_req),    0);
      chk("rst_instr_valid", 32'(instr_valid), 0);
      chk("rst_halted",      32'(halted),      0);
      chk("rst_pc",          32'(pc),          0);
      chk("rst_instr",       32'(instr),       0);
      chk("rst_req_q_empty", 32'(req_q.size()), 0);
      chk("rst_dec_q_empty", 32'(dec_q.size()), 0);
      req_q.delete();
      dec_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compare every accepted memory request and every decode consume.
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req && imem_ack) begin
            n_cmp++;
            if (req_q.size() == 0) begin
               n_bad++;
               $display("FAIL req_addr: unexpected request at 0x%0h", imem_addr);
            end else begin
               logic [PW-1:0] e;
               e = req_q.pop_front();
               if (imem_addr !== e) begin
                  n_bad++;
                  $display("FAIL req_addr: got 0x%0h expected 0x%0h", imem_addr, e);
               end
            end
         end
         if (instr_valid && (instr_ready || take_branch)) begin
            n_cmp++;
            if (dec_q.size() == 0) begin
               n_bad++;
               $display("FAIL decode: unexpected instr 0x%0h pc 0x%0h", instr, pc);
            end else begin
               logic [PW+IW-1:0] e;
               e = dec_q.pop_front();
               if ({pc, instr} !== e) begin
                  n_bad++;
                  $display("FAIL decode: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                           pc, instr, e[PW+IW-1:IW], e[IW-1:0]);
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_imem_req",    32'(imem_req),    0);
      chk("reset_instr_valid", 32'(instr_valid), 0);
      chk("reset_halted",      32'(halted),      0);
      chk("reset_pc",          32'(pc),          0);
      chk("reset_instr",       32'(instr),       0);
      chk("reset_pc_plus_1",   32'(pc_plus_1),   1);

      // Release; the START cycle ignores the ack that is already high.
      rst_n = 1'b1;
      step(1, 8'hCC, 1, 0, '0, 0);
      chk("first_req",  32'(imem_req),    1);
      chk("first_addr", 32'(imem_addr),   0);
      chk("first_val",  32'(instr_valid), 0);

      // Sequential fetch with ack and ready high.
      for (int a = 0; a < 4; a++) begin
         step(1, (a == 3) ? 8'hA5 : IW'(8'h10 + a), (a != 3), 0, '0, 0);
         chk("seq_valid", 32'(instr_valid), 1);
         chk("seq_instr", 32'(instr),       (a == 3) ? 32'hA5 : 32'(8'h10 + a));
         chk("seq_pc",    32'(pc),          32'(a));
         chk("seq_pc_p1", 32'(pc_plus_1),   32'(a + 1));
         chk("seq_noreq", 32'(imem_req),    0);
         if (a < 3) begin
            step(1, 8'h00, 1, 0, '0, 0);
            chk("seq_addr", 32'(imem_addr), 32'(a + 1));
            chk("seq_req",  32'(imem_req),  1);
         end
      end

      // Stall in HOLD at pc=3 with 0xA5.
      for (int i = 0; i < 5; i++) begin
         step(1, 8'hFF, 0, 0, '0, 0);
         chk("stall_instr", 32'(instr),       32'hA5);
         chk("stall_pc",    32'(pc),          3);
         chk("stall_valid", 32'(instr_valid), 1);
         chk("stall_req",   32'(imem_req),    0);
      end

      // Advance to HOLD at pc=5, then redirect from HOLD.
      step(0, 8'h00, 1, 0, '0, 0);
      chk("adv_addr4", 32'(imem_addr), 4);
      step(1, 8'h54, 0, 0, '0, 0);
      step(0, 8'h00, 1, 0, '0, 0);
      step(1, 8'h55, 0, 0, '0, 0);
      chk("hold5_pc",    32'(pc),    5);
      chk("hold5_instr", 32'(instr), 32'h55);
      step(0, 8'h00, 0, 1, 10'h120, 0);
      chk("redir_valid", 32'(instr_valid), 0);
      chk("redir_req",   32'(imem_req),    1);
      chk("redir_addr",  32'(imem_addr),   32'h120);

      // Redirect while the request at 0x120 is in flight.
      step(0, 8'h00, 0, 1, 10'h040, 0);
      chk("inflight_addr1", 32'(imem_addr), 32'h120);
      step(0, 8'h00, 0, 0, '0, 0);
      chk("inflight_addr2", 32'(imem_addr), 32'h120);
      step(0, 8'h00, 0, 0, '0, 0);
      step(1, 8'hEE, 1, 0, '0, 0);
      chk("inflight_drop", 32'(instr_valid), 0);
      chk("inflight_req",  32'(imem_req),    1);
      chk("inflight_new",  32'(imem_addr),   32'h040);
      step(1, 8'h33, 0, 0, '0, 0);
      chk("after_instr", 32'(instr), 32'h33);
      chk("after_pc",    32'(pc),    32'h040);

      // Wrap-around at the top of the address space.
      step(0, 8'h00, 0, 1, 10'h3FF, 0);
      chk("wrap_addr", 32'(imem_addr), 32'h3FF);
      chk("wrap_p1",   32'(pc_plus_1), 0);
      step(1, 8'h44, 0, 0, '0, 0);
      step(0, 8'h00, 1, 0, '0, 0);
      chk("wrap_next", 32'(imem_addr), 0);
      chk("wrap_req",  32'(imem_req),  1);

      // Halt from HOLD at pc=7 with instr_ready.
      step(1, 8'h70, 0, 0, '0, 0);
      step(0, 8'h00, 0, 1, 10'd7, 0);
      step(1, 8'h77, 0, 0, '0, 0);
      chk("pre_halt_pc", 32'(pc), 7);
      step(0, 8'h00, 1, 0, '0, 1);
      chk("halt_halted", 32'(halted),      1);
      chk("halt_pc",     32'(pc),          8);
      chk("halt_req",    32'(imem_req),    0);
      chk("halt_valid",  32'(instr_valid), 0);
      for (int i = 0; i < 4; i++) begin
         rstep(1'($urandom_range(0, 1)));
         chk("halted_stays", 32'(halted),   1);
         chk("halted_pc",    32'(pc),       8);
         chk("halted_noreq", 32'(imem_req), 0);
      end

      do_reset();
      step(0, 8'h00, 0, 0, '0, 0);
      chk("restart_req",  32'(imem_req),  1);
      chk("restart_addr", 32'(imem_addr), 0);
      chk("restart_halt", 32'(halted),    0);

      // Randomized rounds: alternately end with halt or with reset mid-request.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 300; i++) begin
            rstep(0);
            check_model();
         end
         if (r % 2 == 0) begin
            int budget;
            rstep(1);
            check_model();
            budget = 200;
            while (m_mode != P_STOP && budget > 0) begin
               rstep(0);
               check_model();
               budget--;
            end
            chk("round_halted", 32'(halted), 1);
            for (int i = 0; i < 5; i++) begin
               rstep(1'($urandom_range(0, 1)));
               check_model();
            end
         end else begin
            int budget;
            budget = 50;
            while (m_mode != P_AWAIT && budget > 0) begin
               rstep(0);
               budget--;
            end
            chk("round_in_fetch", 32'(imem_req), 1);
         end
         do_reset();
         step(1, IW'($urandom), 1, 0, '0, 0);
         check_model();
      end

      chk("final_req_q_empty", 32'(req_q.size()), 0);
      chk("final_dec_q_empty", 32'(dec_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
